// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one I2C master engine among four requesters.
// Every output comes from a register. One combinational block computes all next values.
module i2c_bus_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [27:0] req_addr,
    input  logic [3:0]  req_rw,
    input  logic [3:0]  req_two_bytes,
    input  logic [31:0] req_wdata,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        m_start,
    output logic [6:0]  m_slave_addr,
    output logic        m_rw,
    output logic        m_two_bytes,
    output logic [7:0]  m_write_data,
    input  logic        m_ready,
    input  logic [15:0] m_read_data
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  gnt_reg, gnt_next;
    logic [3:0]  done_reg, done_next;
    logic        err_reg, err_next;
    logic [15:0] rdata_reg, rdata_next;
    logic        busy_reg, busy_next;
    logic        m_start_reg, m_start_next;
    logic [6:0]  m_addr_reg, m_addr_next;
    logic        m_rw_reg, m_rw_next;
    logic        m_two_reg, m_two_next;
    logic [7:0]  m_wdata_reg, m_wdata_next;
    logic [1:0]  ptr_reg, ptr_next;
    logic [15:0] tcnt_reg, tcnt_next;

    logic [6:0] addr_arr  [4];
    logic [7:0] wdata_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[7*gi +: 7];
            assign wdata_arr[gi] = req_wdata[8*gi +: 8];
        end
    endgenerate

    // The winner is the first active request found when searching upward from ptr, wrapping from 3 to 0.
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_reg;
        cand      = ptr_reg;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_reg + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    logic timeout_hit;
    assign timeout_hit = (tcnt_reg == TIMEOUT - 16'd1);

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        done_next    = 4'b0000;
        err_next     = err_reg;
        rdata_next   = rdata_reg;
        m_start_next = 1'b0;
        m_addr_next  = m_addr_reg;
        m_rw_next    = m_rw_reg;
        m_two_next   = m_two_reg;
        m_wdata_next = m_wdata_reg;
        ptr_next     = ptr_reg;
        tcnt_next    = tcnt_reg;

        case (state_reg)
            IDLE: begin
                if (m_ready && win_found) begin
                    gnt_next     = 4'b0001 << win_idx;
                    m_addr_next  = addr_arr[win_idx];
                    m_rw_next    = req_rw[win_idx];
                    m_two_next   = req_two_bytes[win_idx];
                    m_wdata_next = wdata_arr[win_idx];
                    ptr_next     = win_idx + 2'd1;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                m_start_next = 1'b1;
                tcnt_next    = 16'd0;
                state_next   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A slow engine may never drop m_ready, so the timeout also runs in this state.
                if (timeout_hit) begin
                    err_next   = 1'b1;
                    done_next  = gnt_reg;
                    state_next = FINISH;
                end else begin
                    tcnt_next = tcnt_reg + 16'd1;
                    if (!m_ready) begin
                        state_next = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (m_ready) begin
                    rdata_next = m_read_data;
                    err_next   = 1'b0;
                    done_next  = gnt_reg;
                    state_next = FINISH;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    done_next  = gnt_reg;
                    state_next = FINISH;
                end else begin
                    tcnt_next = tcnt_reg + 16'd1;
                end
            end
            FINISH: begin
                gnt_next   = 4'b0000;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            gnt_reg     <= 4'b0000;
            done_reg    <= 4'b0000;
            err_reg     <= 1'b0;
            rdata_reg   <= 16'd0;
            busy_reg    <= 1'b0;
            m_start_reg <= 1'b0;
            m_addr_reg  <= 7'd0;
            m_rw_reg    <= 1'b0;
            m_two_reg   <= 1'b0;
            m_wdata_reg <= 8'd0;
            ptr_reg     <= 2'd0;
            tcnt_reg    <= 16'd0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            rdata_reg   <= rdata_next;
            busy_reg    <= busy_next;
            m_start_reg <= m_start_next;
            m_addr_reg  <= m_addr_next;
            m_rw_reg    <= m_rw_next;
            m_two_reg   <= m_two_next;
            m_wdata_reg <= m_wdata_next;
            ptr_reg     <= ptr_next;
            tcnt_reg    <= tcnt_next;
        end
    end

    assign gnt          = gnt_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign rdata        = rdata_reg;
    assign busy         = busy_reg;
    assign m_start      = m_start_reg;
    assign m_slave_addr = m_addr_reg;
    assign m_rw         = m_rw_reg;
    assign m_two_bytes  = m_two_reg;
    assign m_write_data = m_wdata_reg;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares them whenever m_start or done appears.
module tb_i2c_bus_arbiter;

    localparam logic [15:0] TMO = 16'd100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'h0;
    logic [27:0] req_addr = 28'h0;
    logic [3:0]  req_rw = 4'h0;
    logic [3:0]  req_two_bytes = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [15:0] rdata;
    logic        busy;
    logic        m_start;
    logic [6:0]  m_slave_addr;
    logic        m_rw;
    logic        m_two_bytes;
    logic [7:0]  m_write_data;
    logic        m_ready = 1'b1;
    logic [15:0] m_read_data = 16'h0;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_two_bytes(req_two_bytes), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .busy(busy), .m_start(m_start),
        .m_slave_addr(m_slave_addr), .m_rw(m_rw), .m_two_bytes(m_two_bytes),
        .m_write_data(m_write_data), .m_ready(m_ready), .m_read_data(m_read_data)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [6:0] addr;
        logic       rw;
        logic       two;
        logic [7:0] wdata;
    } grant_t;

    typedef struct {
        logic [3:0]  done;
        logic        err;
        logic [15:0] rdata;
        int          lat;
    } resp_t;

    grant_t exp_g_q[$];
    resp_t  exp_r_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mstart_cnt = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int gnt_cyc = 0;
    int done_cyc = -10;
    logic txn_open = 1'b0;
    logic [3:0] prev_gnt = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: busy for eng_busy cycles after m_start, then either echoes the command or returns eng_rdata.
    int          eng_busy = 5;
    int          eng_cnt = 0;
    logic        eng_hang = 1'b0;
    logic        eng_fixed = 1'b0;
    logic [15:0] eng_rdata = 16'h0;
    logic [15:0] eng_echo = 16'h0;

    always @(posedge clk) begin
        if (m_start && m_ready) begin
            m_ready  <= 1'b0;
            eng_cnt  <= eng_busy;
            eng_echo <= {m_write_data, 1'b0, m_slave_addr};
        end else if (!m_ready && !eng_hang) begin
            if (eng_cnt <= 1) begin
                m_ready     <= 1'b1;
                m_read_data <= eng_fixed ? eng_rdata : eng_echo;
            end
            eng_cnt <= eng_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        grant_t g;
        resp_t  r;
        if (rst || !busy) txn_open = 1'b0;
        if (rst) begin
            prev_gnt = 4'h0;
        end else begin
            if (gnt != 4'h0 && prev_gnt == 4'h0) gnt_cyc = cyc;
            prev_gnt = gnt;
            if (cyc == done_cyc + 1) check("busy_after_done", 64'(busy), 64'(0));
            if (m_start) begin
                mstart_cnt++;
                check("start_while_open", 64'(txn_open), 64'(0));
                check("gnt_to_start", 64'(cyc - gnt_cyc), 64'(1));
                check("busy_at_start", 64'(busy), 64'(1));
                if (exp_g_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_start: gnt=%b addr=%h, expected no start", gnt, m_slave_addr);
                end else begin
                    g = exp_g_q.pop_front();
                    check("grant_cmd", 64'({gnt, m_slave_addr, m_rw, m_two_bytes, m_write_data}), 64'(g));
                end
                txn_open  = 1'b1;
                start_cyc = cyc;
            end
            if (done != 4'h0) begin
                done_cnt++;
                done_cyc = cyc;
                $display("txn %0d: done=%b err=%b rdata=%h latency=%0d", done_cnt, done, err, rdata, cyc - start_cyc);
                if (exp_r_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=%b, expected none", done);
                end else begin
                    r = exp_r_q.pop_front();
                    check("done", 64'(done), 64'(r.done));
                    check("gnt_held", 64'(gnt), 64'(r.done));
                    check("err", 64'(err), 64'(r.err));
                    check("rdata", 64'(rdata), 64'(r.rdata));
                    check("latency", 64'(cyc - start_cyc), 64'(r.lat));
                end
                txn_open = 1'b0;
            end
        end
    end

    task automatic push_grant(input int k);
        grant_t g;
        g.gnt   = 4'(4'b0001 << k);
        g.addr  = req_addr[7*k +: 7];
        g.rw    = req_rw[k];
        g.two   = req_two_bytes[k];
        g.wdata = req_wdata[8*k +: 8];
        exp_g_q.push_back(g);
    endtask

    task automatic push_resp(input int k, input logic e, input logic [15:0] rd, input int lat);
        resp_t r;
        r.done  = 4'(4'b0001 << k);
        r.err   = e;
        r.rdata = rd;
        r.lat   = lat;
        exp_r_q.push_back(r);
    endtask

    function automatic logic [15:0] echo_of(input int k);
        return {req_wdata[8*k +: 8], 1'b0, req_addr[7*k +: 7]};
    endfunction

    task automatic wait_mstart(input int target, input int budget);
        int n = 0;
        while (mstart_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("mstart_arrived", 64'(mstart_cnt >= target), 64'(1));
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_arrived", 64'(done_cnt >= target), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected $finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({gnt, done, err, rdata, busy, m_start, m_slave_addr, m_rw, m_two_bytes, m_write_data}), 64'(0));
        rst = 1'b0;

        // Round robin from reset: 0,1,2,3,0 with all requests held.
        req_addr      = {7'h13, 7'h12, 7'h11, 7'h10};
        req_rw        = 4'b1010;
        req_two_bytes = 4'b0110;
        req_wdata     = 32'hD3C2B1A0;
        eng_busy      = 5;
        for (int k = 0; k < 5; k++) begin
            push_grant(k % 4);
            push_resp(k % 4, 1'b0, echo_of(k % 4), 7);
        end
        req = 4'b1111;
        wait_mstart(5, 100);
        req = 4'b0000;
        wait_done(5, 40);

        // Single read from requester 2.
        req_addr       = 28'h0;
        req_addr[20:14] = 7'h4A;
        req_rw         = 4'b0100;
        req_two_bytes  = 4'b0000;
        req_wdata      = 32'h005E0000;
        eng_busy       = 20;
        eng_fixed      = 1'b1;
        eng_rdata      = 16'h1234;
        push_grant(2);
        push_resp(2, 1'b0, 16'h1234, 22);
        t = mstart_cnt + 1;
        req = 4'b0100;
        wait_mstart(t, 20);
        req = 4'b0000;
        wait_done(t, 60);

        // Timeout: engine never returns ready, rdata keeps 0x1234.
        req_addr[6:0]  = 7'h2C;
        req_rw         = 4'b0000;
        req_wdata[7:0] = 8'h99;
        eng_hang       = 1'b1;
        push_grant(0);
        push_resp(0, 1'b1, 16'h1234, 100);
        t = mstart_cnt + 1;
        req = 4'b0001;
        wait_mstart(t, 20);
        req = 4'b0000;
        wait_done(t, 200);
        @(negedge clk);
        eng_hang  = 1'b0;
        eng_fixed = 1'b0;
        n = 0;
        while (!m_ready && n < 60) begin
            @(negedge clk);
            n++;
        end

        // Reset during WAIT_DONE, then requester 1 wins 4'b1010 once the engine is idle.
        req_addr[13:7]  = 7'h21;
        req_rw          = 4'b0010;
        req_wdata[15:8] = 8'h42;
        push_grant(1);
        t = mstart_cnt + 1;
        req = 4'b0010;
        wait_mstart(t, 20);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midtxn_reset_outputs", 64'({gnt, done, err, rdata, busy, m_start, m_slave_addr, m_rw, m_two_bytes, m_write_data}), 64'(0));
        rst = 1'b0;
        req_addr[27:21] = 7'h35;
        req_wdata[31:24] = 8'h77;
        req = 4'b1010;
        push_grant(1);
        push_resp(1, 1'b0, echo_of(1), 22);
        @(negedge clk);
        check("no_grant_engine_busy", 64'({gnt, busy}), 64'(0));
        t = mstart_cnt + 1;
        wait_mstart(t, 60);
        req = 4'b0000;
        wait_done(done_cnt + 1, 60);

        // Requester 3 granted; request dropped and inputs changed mid-transaction.
        req_addr[27:21]  = 7'h35;
        req_rw           = 4'b0000;
        req_two_bytes    = 4'b1000;
        req_wdata[31:24] = 8'hC3;
        push_grant(3);
        push_resp(3, 1'b0, echo_of(3), 22);
        t = mstart_cnt + 1;
        req = 4'b1000;
        wait_mstart(t, 20);
        repeat (4) @(negedge clk);
        req           = 4'b0000;
        req_addr      = ~req_addr;
        req_wdata     = 32'h5A5A5A5A;
        req_rw        = 4'b1111;
        req_two_bytes = 4'b0000;
        @(negedge clk);
        check("hold_cmd", 64'({m_slave_addr, m_rw, m_two_bytes, m_write_data}), 64'({7'h35, 1'b0, 1'b1, 8'hC3}));
        wait_done(done_cnt + 1, 60);
        @(negedge clk);
        check("idle_keeps_cmd", 64'({m_slave_addr, m_write_data}), 64'({7'h35, 8'hC3}));

        check("grant_queue_empty", 64'(exp_g_q.size()), 64'(0));
        check("resp_queue_empty", 64'(exp_r_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Parameters
REQ-001 The block SHALL have parameter TIMEOUT, default 16'd50000, the maximum cycles from m_start to transaction completion.

Interface
REQ-002 The block SHALL have port clk, input, 1, the single system clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4, one transaction request per requester (index 0..3).
REQ-005 The block SHALL have port req_addr, input, 28, packed 7-bit slave addresses; requester i uses bits [7i+6:7i].
REQ-006 The block SHALL have port req_rw, input, 4, per-requester direction: 0 = write, 1 = read.
REQ-007 The block SHALL have port req_two_bytes, input, 4, per-requester length: 1 = two bytes, 0 = one byte.
REQ-008 The block SHALL have port req_wdata, input, 32, packed 8-bit write data; requester i uses bits [8i+7:8i].
REQ-009 The block SHALL have port gnt, output, 4, one-hot grant, held for the whole transaction.
REQ-010 The block SHALL have port done, output, 4, one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port err, output, 1, valid with done; 1 = timeout.
REQ-012 The block SHALL have port rdata, output, 16, read data latched at completion.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have ports m_start (output, 1), m_slave_addr (output, 7), m_rw (output, 1), m_two_bytes (output, 1) and m_write_data (output, 8), all driving the shared i2c master engine.
REQ-015 The block SHALL have ports m_ready (input, 1), meaning the engine is idle, and m_read_data (input, 16), the engine result.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and FINISH.
REQ-018 IDLE: when m_ready=1 and req!=0, the block SHALL pick the winner round-robin, starting the search at index ptr and wrapping 3->0.
  - It SHALL set gnt one-hot.
  - It SHALL latch the winner's addr/rw/two_bytes/wdata onto the m_* outputs.
  - It SHALL set ptr to winner+1 mod 4 and go to ISSUE.
REQ-019 IDLE with m_ready=0 SHALL grant nothing and wait.
REQ-020 ISSUE: the block SHALL drive m_start=1 for exactly this one cycle, clear the timeout counter, and go to WAIT_BUSY.
REQ-021 WAIT_BUSY: on m_ready=0 the block SHALL go to WAIT_DONE; otherwise it SHALL stay.
REQ-022 WAIT_DONE: on m_ready=1 the block SHALL latch m_read_data into rdata, set err=0 and go to FINISH.
REQ-023 FINISH: the block SHALL pulse done[winner]=1 for one cycle, then clear gnt and go to IDLE.
  - Grant to done latency is therefore 3 + engine busy cycles.
REQ-024 The timeout counter SHALL increment every cycle in WAIT_BUSY and WAIT_DONE.
REQ-025 When the counter reaches TIMEOUT-1 without completion, the block SHALL set err=1, leave rdata unchanged and go to FINISH.
REQ-026 For write transactions, rdata SHALL still be updated with m_read_data (don't-care content).
REQ-027 Deassertion of req[winner] before done SHALL NOT abort the transaction; done SHALL still pulse.
REQ-028 Changes on req_addr, req_rw, req_two_bytes or req_wdata after grant SHALL NOT affect the m_* outputs.
REQ-029 A requester re-asserting in the cycle after its done SHALL be arbitrated normally; round-robin guarantees no requester waits more than 3 other transactions.
REQ-030 No new grant SHALL be issued while busy=1.
REQ-031 The m_* outputs SHALL keep their last values between transactions.

Reset
REQ-032 On rst=1 at a clk edge, all of the following SHALL be cleared, regardless of state (mid-transaction included): gnt, done, err, rdata, m_start, m_slave_addr, m_rw, m_two_bytes, m_write_data, busy, ptr, timeout counter; the FSM SHALL go to IDLE.
REQ-033 The first transaction after reset SHALL favour requester 0.
REQ-034 An engine transaction in flight during reset SHALL be ignored; a subsequent grant SHALL wait for m_ready=1.

Verification
REQ-035 Single request: req=4'b0100, req_addr[20:14]=7'h4A, req_rw[2]=1, the engine model goes busy for 20 cycles and returns 16'h1234.
  - Required: gnt=4'b0100, then m_start one cycle with m_slave_addr=7'h4A, m_rw=1.
  - Required: done=4'b0100 with rdata=16'h1234 and err=0.
REQ-036 Round-robin: req=4'b1111 held continuously.
  - Required: grants in order 0,1,2,3,0.
  - Required: each done before the next gnt, and m_start never asserted while busy=1.
REQ-037 Timeout: TIMEOUT=100, the engine never returns m_ready=1.
  - Required: done pulses 100 cycles after m_start with err=1 and rdata unchanged.
  - Required: busy returns to 0 next cycle.
REQ-038 Reset mid-transaction: rst=1 in WAIT_DONE.
  - Required: next cycle all outputs are 0 and the FSM is in IDLE.
  - Required: the next req=4'b1010 is granted to requester 1.
REQ-039 Request drop and data hold: requester 3 granted, req[3] dropped and req_wdata changed during WAIT_DONE.
  - Required: m_write_data keeps the latched value.
  - Required: done[3] still pulses.
